// File: rtl/led_pkg.sv
// Shared constants for the LED fader: colour bit positions and fade FSM states.
package led_pkg;

  localparam int unsigned COL_R = 2;
  localparam int unsigned COL_G = 1;
  localparam int unsigned COL_B = 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: working duty that ramps toward its target, a per-period
// shadow copy of that duty, and the registered PWM compare.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                target_on,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                cnt_wrap,
  output logic                led,
  output logic                at_target
);

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] app_q;
  logic                led_q;

  assign target    = target_on ? '1 : '0;
  assign at_target = (duty_q == target);
  assign led       = led_q;

  // Stepping only while off-target gives saturation without overshoot or wrap.
  always_comb begin
    duty_d = duty_q;
    if (tick && !at_target) begin
      duty_d = target_on ? duty_q + 1'b1 : duty_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      app_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      if (cnt_wrap) begin
        app_q <= duty_q;
      end
      led_q <= (cnt < app_q);
    end
  end

endmodule

// File: rtl/led_rgb_fader.sv
// RGB PWM driver with cross-fading between 3-bit colour codes; holds the
// colour register, fade FSM, fade tick divider and free-running PWM counter.
module led_rgb_fader
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned FADE_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       fading
);

  localparam int unsigned TW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FADE_DIV - 1);

  logic [2:0]          col_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic                cnt_wrap;
  logic [TW-1:0]       tick_q, tick_d;
  fade_state_e         state_q, state_d;
  logic                tick;
  logic                at_r, at_g, at_b;
  logic                all_at;

  assign cnt_wrap = (cnt_q == '1);
  assign all_at   = at_r & at_g & at_b;
  assign tick     = (state_q == FADING) && (tick_q == TICK_LAST);
  assign fading   = (state_q == FADING);

  // The divider keeps its phase across mid-fade colour changes; only IDLE clears it.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!all_at) begin
          state_d = FADING;
        end
      end
      FADING: begin
        if (all_at) begin
          state_d = IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick ? '0 : tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      state_q <= IDLE;
    end else begin
      col_q   <= colour;
      cnt_q   <= cnt_q + 1'b1;
      tick_q  <= tick_d;
      state_q <= state_d;
    end
  end

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_r (
    .clk       (clk),
    .rst       (rst),
    .target_on (col_q[COL_R]),
    .tick      (tick),
    .cnt       (cnt_q),
    .cnt_wrap  (cnt_wrap),
    .led       (led_r),
    .at_target (at_r)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_g (
    .clk       (clk),
    .rst       (rst),
    .target_on (col_q[COL_G]),
    .tick      (tick),
    .cnt       (cnt_q),
    .cnt_wrap  (cnt_wrap),
    .led       (led_g),
    .at_target (at_g)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_b (
    .clk       (clk),
    .rst       (rst),
    .target_on (col_q[COL_B]),
    .tick      (tick),
    .cnt       (cnt_q),
    .cnt_wrap  (cnt_wrap),
    .led       (led_b),
    .at_target (at_b)
  );

endmodule
